// File: rtl/mtimer_pkg.sv
// Shared register offsets and CTRL bit positions for the mtimer peripheral.
package mtimer_pkg;

  localparam logic [2:0] MTIMER_OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIMER_OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMER_OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMER_OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MTIMER_OFF_CTRL        = 3'd4;

  localparam int MTIMER_CTRL_EN   = 0;
  localparam int MTIMER_CTRL_PEND = 1;

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk by PRESCALE to produce a single-cycle mtime tick; holds its count while disabled.
module mtimer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = en && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 32-bit bus, registered level interrupt.
// Optional MTIMER_SNAPSHOT_EN: MTIME_LO reads latch mtime[63:32] for a coherent MTIME_HI read.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq_mtimecmp
);

  logic [63:0] mtime_reg, mtime_next;
  logic [63:0] mtimecmp_reg, mtimecmp_next;
  logic        en_reg, en_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        irq_reg;
  logic        tick;
  logic [31:0] bit_mask;
  logic [31:0] mtime_hi_rd;
  logic [31:0] ctrl_rd;
  logic        wr_en, rd_en, mtime_wr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [31:0] msk);
    return (cur & ~msk) | (wd & msk);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bit_mask[8*gi +: 8] = {8{wmask[gi]}};
  end

  assign wr_en    = sel && we && (|wmask);
  assign rd_en    = sel && re;
  assign mtime_wr = wr_en && (addr == MTIMER_OFF_MTIME_LO || addr == MTIMER_OFF_MTIME_HI);

  // mtime writes deliberately leave the prescaler phase untouched.
  mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en_reg),
    .clear (1'b0),
    .tick  (tick)
  );

  always_comb begin
    mtime_next    = mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    en_next       = en_reg;
    if (wr_en) begin
      case (addr)
        MTIMER_OFF_MTIME_LO:    mtime_next[31:0]     = merge_bytes(mtime_reg[31:0], wdata, bit_mask);
        MTIMER_OFF_MTIME_HI:    mtime_next[63:32]    = merge_bytes(mtime_reg[63:32], wdata, bit_mask);
        MTIMER_OFF_MTIMECMP_LO: mtimecmp_next[31:0]  = merge_bytes(mtimecmp_reg[31:0], wdata, bit_mask);
        MTIMER_OFF_MTIMECMP_HI: mtimecmp_next[63:32] = merge_bytes(mtimecmp_reg[63:32], wdata, bit_mask);
        MTIMER_OFF_CTRL:        if (wmask[0]) en_next = wdata[MTIMER_CTRL_EN];
        default: ;
      endcase
    end
    if (tick && !mtime_wr) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= '0;
    end else if (rd_en && addr == MTIMER_OFF_MTIME_LO) begin
      shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtime_hi_rd = shadow_reg;
`else
  assign mtime_hi_rd = mtime_reg[63:32];
`endif

  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[MTIMER_CTRL_EN]   = en_reg;
    ctrl_rd[MTIMER_CTRL_PEND] = irq_reg;
    rdata_next                = rdata_reg;
    if (rd_en) begin
      case (addr)
        MTIMER_OFF_MTIME_LO:    rdata_next = mtime_reg[31:0];
        MTIMER_OFF_MTIME_HI:    rdata_next = mtime_hi_rd;
        MTIMER_OFF_MTIMECMP_LO: rdata_next = mtimecmp_reg[31:0];
        MTIMER_OFF_MTIMECMP_HI: rdata_next = mtimecmp_reg[63:32];
        MTIMER_OFF_CTRL:        rdata_next = ctrl_rd;
        default:                rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= CMP_RESET;
      en_reg       <= 1'b1;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      en_reg       <= en_next;
      rdata_reg    <= rdata_next;
      irq_reg      <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign rdata        = rdata_reg;
  assign irq_mtimecmp = irq_reg;

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench for mtimer: DUT A uses PRESCALE=1, DUT B uses PRESCALE=4.
module tb_mtimer;

  typedef struct {
    string       name;
    int          which;
    logic [31:0] exp;
  } exp_t;

  localparam logic [2:0] A_LO = 3'd0, A_HI = 3'd1, A_CLO = 3'd2, A_CHI = 3'd3, A_CTRL = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel_a = 1'b0, sel_b = 1'b0;
  logic [2:0]  addr = '0;
  logic        re = 1'b0, we = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  int   checks = 0;
  int   errors = 0;
  logic mon_rd = 1'b0;
  logic end_chk = 1'b0;
  logic [31:0] snap_exp;

  exp_t rd_q[$];
  exp_t lvl_q[$];

  always #5 clk = ~clk;

  mtimer #(.PRESCALE(1)) u_dut_a (
    .clk(clk), .reset(reset), .sel(sel_a), .addr(addr), .re(re), .we(we),
    .wmask(wmask), .wdata(wdata), .rdata(rdata_a), .irq_mtimecmp(irq_a)
  );

  mtimer #(.PRESCALE(4)) u_dut_b (
    .clk(clk), .reset(reset), .sel(sel_b), .addr(addr), .re(re), .we(we),
    .wmask(wmask), .wdata(wdata), .rdata(rdata_b), .irq_mtimecmp(irq_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Read data is valid the cycle after a strobed read edge.
  always @(posedge clk) mon_rd <= (sel_a || sel_b) && re;

  always @(negedge clk) begin
    exp_t e;
    if (mon_rd) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check(e.name, (e.which == 0) ? rdata_a : rdata_b, e.exp);
      end
    end
    while (lvl_q.size() > 0) begin
      e = lvl_q.pop_front();
      case (e.which)
        0:       check(e.name, {31'd0, irq_a}, e.exp);
        1:       check(e.name, rdata_a, e.exp);
        2:       check(e.name, {31'd0, irq_b}, e.exp);
        default: check(e.name, rdata_b, e.exp);
      endcase
    end
    if (end_chk) check("rd_queue_drained", rd_q.size(), 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input int dut, input logic [2:0] a, input logic do_rd, input logic do_wr,
                     input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp,
                     input string name);
    if (do_rd) rd_q.push_back('{name, dut, exp});
    sel_a = (dut == 0);
    sel_b = (dut == 1);
    addr  = a;
    re    = do_rd;
    we    = do_wr;
    wdata = wd;
    wmask = wm;
    cyc();
    sel_a = 1'b0;
    sel_b = 1'b0;
    re    = 1'b0;
    we    = 1'b0;
  endtask

  task automatic rd(input int dut, input logic [2:0] a, input logic [31:0] exp, input string name);
    bus(dut, a, 1'b1, 1'b0, 32'd0, 4'h0, exp, name);
  endtask

  task automatic wr(input int dut, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] wm);
    bus(dut, a, 1'b0, 1'b1, wd, wm, 32'd0, "");
  endtask

  task automatic lvl(input int which, input logic [31:0] exp, input string name);
    lvl_q.push_back('{name, which, exp});
  endtask

  initial begin
`ifdef MTIMER_SNAPSHOT_EN
    snap_exp = 32'd1;
`else
    snap_exp = 32'd2;
`endif
    repeat (3) cyc();
    reset = 1'b0;
    lvl(0, 0, "a_reset_irq");
    lvl(1, 0, "a_reset_rdata");
    lvl(2, 0, "b_reset_irq");
    lvl(3, 0, "b_reset_rdata");

    // DUT B, PRESCALE=4: ticks on every fourth edge after reset.
    repeat (12) cyc();
    rd(1, A_LO, 32'd3, "b_mtime_after_12");
    wr(1, A_CTRL, 32'd0, 4'h1);
    repeat (20) cyc();
    rd(1, A_LO, 32'd3, "b_frozen");
    rd(1, A_CTRL, 32'd0, "b_ctrl_disabled");
    wr(1, A_CTRL, 32'd1, 4'h1);
    cyc();
    rd(1, A_LO, 32'd3, "b_resume_pre");
    rd(1, A_LO, 32'd4, "b_resume_held_phase");

    // Reset mid-operation with a read in flight on A.
    reset = 1'b1;
    rd_q.push_back('{"a_read_lost_in_reset", 0, 32'd0});
    sel_a = 1'b1; re = 1'b1; addr = A_LO;
    cyc();
    sel_a = 1'b0; re = 1'b0;
    cyc();
    reset = 1'b0;
    lvl(0, 0, "a_irq_after_reset");

    // DUT A, PRESCALE=1: mtime equals edges since reset release.
    repeat (10) cyc();
    rd(0, A_LO, 32'd10, "a_mtime_10");
    rd(0, A_CHI, 32'hFFFF_FFFF, "a_cmp_hi_reset");
    lvl(0, 0, "a_irq_idle");
    wr(0, A_CHI, 32'd0, 4'hF);
    wr(0, A_CLO, 32'd20, 4'hF);
    repeat (6) cyc();
    lvl(0, 0, "a_irq_at_mtime_20");
    cyc();
    lvl(0, 1, "a_irq_rise");
    rd(0, A_CTRL, 32'd3, "a_ctrl_pend");
    wr(0, A_CLO, 32'd100, 4'hF);
    lvl(0, 1, "a_irq_lag_after_raise");
    cyc();
    lvl(0, 0, "a_irq_drop");

    // Wrap of the full 64-bit counter.
    wr(0, A_HI, 32'hFFFF_FFFF, 4'hF);
    wr(0, A_LO, 32'hFFFF_FFFE, 4'hF);
    lvl(0, 1, "a_irq_high_time");
    rd(0, A_LO, 32'hFFFF_FFFE, "a_wrap_lo_pre");
    rd(0, A_HI, 32'hFFFF_FFFF, "a_wrap_hi_pre");
    lvl(0, 1, "a_irq_lag_at_wrap");
    cyc();
    lvl(0, 0, "a_irq_after_wrap");
    rd(0, A_LO, 32'd1, "a_wrap_lo_post");
    rd(0, A_HI, 32'd0, "a_wrap_hi_post");

    // Byte lanes, unmapped offset, wmask=0.
    wr(0, A_CLO, 32'hFFFF_FFFF, 4'hF);
    wr(0, A_CLO, 32'hAABB_CCDD, 4'b0101);
    rd(0, A_CLO, 32'hFFBB_FFDD, "a_byte_mask");
    wr(0, A_CLO, 32'h0000_0000, 4'h0);
    rd(0, A_CLO, 32'hFFBB_FFDD, "a_wmask_zero");
    rd(0, 3'd6, 32'd0, "a_unmapped");

    // Simultaneous read and write returns the pre-write value.
    wr(0, A_LO, 32'h0000_1000, 4'hF);
    bus(0, A_LO, 1'b1, 1'b1, 32'h0000_5555, 4'hF, 32'h0000_1000, "a_rw_same_cycle");
    rd(0, A_LO, 32'h0000_5555, "a_after_rw");

    // LO-then-HI sample across a carry into the upper word.
    wr(0, A_HI, 32'd1, 4'hF);
    wr(0, A_LO, 32'hFFFF_FFFF, 4'hF);
    rd(0, A_LO, 32'hFFFF_FFFF, "a_snap_lo");
    repeat (5) cyc();
    rd(0, A_HI, snap_exp, "a_snap_hi");
    rd(0, A_CTRL, 32'd3, "a_ctrl_final");

    repeat (3) cyc();
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    end_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
